zelda_sprite_fetch: RTL and testbench
=====================================

# zelda_sprite_fetch

Per-pixel sprite fetch stage that sits directly upstream of the 16-entry sprite palette lookup. It converts the VGA raster position and the player's latched position, facing direction and walk state into a synchronous sprite-ROM address. It runs the two-frame walk animation and returns the 4-bit palette index, an opaque-hit flag and a valid flag, pipeline-aligned to the raster. The palette stage consumes `palette_index` directly, and the colour mapper uses `pixel_hit` to choose between sprite and background.

## Interface
- `SPR_LOG2`, 5: log2 of the square sprite edge, giving a 32×32 sprite.
- `ANIM_FRAMES`, 8: number of video frames per walk-animation phase.
- `TRANSP_IDX`, 4'h0: palette index treated as transparent.
- `Clk` input, 1 bit: pixel clock, the only clock.
- `Reset_n` input, 1 bit: asynchronous, active-low reset.
- `frame_start` input, 1 bit: one-cycle pulse at the start of vertical blank.
- `DrawX`, `DrawY` input, 10 bits each: current raster coordinates.
- `blank` input, 1 bit: 1 means the display is active.
- `sprite_x`, `sprite_y` input, 10 bits each: sprite top-left corner.
- `direction` input, 2 bits: 0 = right, 1 = left, 2 = up, 3 = down.
- `moving` input, 1 bit: player is walking.
- `rom_addr` output, 3+2·SPR_LOG2 bits (13 at default): sprite ROM address.
- `rom_q` input, 4 bits: ROM data, valid one cycle after `rom_addr`.
- `palette_index` output, 4 bits: index delivered to the palette stage.
- `pixel_hit` output, 1 bit: pixel lies inside the sprite box and its index is not `TRANSP_IDX`.
- `pixel_valid` output, 1 bit: `blank` delayed to align with `palette_index`.

## Operation
- **Frame-latched state.** On a cycle where `frame_start`=1, the block registers `sprite_x`, `sprite_y`, `direction` and `moving` into `lx`, `ly`, `ldir` and `lmov`. These values stay constant for the whole frame, so the sprite cannot tear mid-frame.
- **Animation.** A counter `acnt` (width $clog2(ANIM_FRAMES)) and a phase bit `aph` update only on `frame_start`, using the newly sampled `moving`:
  - If `moving`=0: `acnt`←0 and `aph`←0.
  - Else if `acnt`==ANIM_FRAMES-1: `acnt`←0 and `aph`←~`aph`.
  - Else: `acnt`←`acnt`+1.
- **Box test.** Use 11-bit zero-extended compares so coordinates near the screen edge do not wrap:
  - `in_box` = (DrawX ≥ lx) && (DrawX < lx+2^SPR_LOG2) && (DrawY ≥ ly) && (DrawY < ly+2^SPR_LOG2).
- **Address.** `rom_addr` = {`ldir`, `aph`, (DrawY−ly)[SPR_LOG2-1:0], (DrawX−lx)[SPR_LOG2-1:0]}.
  - When `in_box`=0, `rom_addr` is 0; the ROM data for that pixel is don't-care.
- **Pipeline.** The block has three register stages:
  - S1 registers `rom_addr`, `in_box_d1` and `blank_d1`.
  - The ROM's own register produces `rom_q` one cycle later, aligned with `in_box_d2` and `blank_d2`.
  - S3 registers the outputs:
    - `palette_index`←(`in_box_d2` ? `rom_q` : TRANSP_IDX).
    - `pixel_hit`←`in_box_d2` & (`rom_q`≠TRANSP_IDX) & `blank_d2`.
    - `pixel_valid`←`blank_d2`.
- **Blanking.** When `blank`=0, `pixel_hit` is forced to 0 three cycles later. `palette_index` still follows the rule above.
- **Reset.** While `Reset_n`=0, all registers clear immediately:
  - `rom_addr`=0, `palette_index`=0, `pixel_hit`=0, `pixel_valid`=0.
  - `lx`=`ly`=0, `ldir`=0, `lmov`=0, `acnt`=0, `aph`=0.
  - Reset takes effect mid-line or mid-frame. After release, outputs carry garbage-free zeros until the pipeline refills, which takes 3 cycles.

## Timing
- `DrawX`/`DrawY`/`blank` sampled at edge N give `rom_addr` at N+1, `rom_q` at N+2, and `palette_index`, `pixel_hit`, `pixel_valid` at N+3. Latency is fixed at 3 cycles, with throughput of one pixel per clock and no stalls.
- A `frame_start` asserted at edge F:
  - updates the latched state and animation state at F+1;
  - affects `rom_addr` from F+1;
  - affects outputs from F+3.
- Pixels already in flight at F complete using the old state.
- `frame_start` together with a box pixel in the same cycle: the address uses the old latched values; the update applies from the next cycle.
- The box is clipped only by the compares. A sprite partly beyond x=639 or y=479 simply never receives a raster hit there.

## Test plan
- **Reset:** `Reset_n`=0 asserted mid-stream while `pixel_hit`=1 → all outputs are 0 in the same cycle. After release, `palette_index`=0 and `pixel_hit`=0 for 3 cycles.
- **Address and latency:**
  - Setup: sprite at (100,50), `direction`=1, `moving`=0, one `frame_start`.
  - Stimulus: DrawX=103, DrawY=52.
  - Required: `rom_addr`=13'b01_0_00010_00011 one cycle later.
  - Required: ROM model returns 4'h7, and three cycles after the DrawX/DrawY sample `palette_index`=7, `pixel_hit`=1.
- **Box edges:**
  - DrawX=131 → `pixel_hit`=1.
  - DrawX=132 → `pixel_hit`=0.
  - DrawX=99 → `pixel_hit`=0.
  - Repeat the same checks with `sprite_x`=630: no wrap, and DrawX=0 → `pixel_hit`=0.
- **Transparency and blank:**
  - `rom_q`=TRANSP_IDX inside the box → `pixel_hit`=0.
  - `blank`=0 inside the box with an opaque `rom_q` → `pixel_hit`=0 and `pixel_valid`=0.
- **Animation:**
  - `moving`=1 for 8 `frame_start` pulses → `aph` toggles from 0 to 1 after the 8th; after the 16th it returns to 0.
  - Dropping `moving` at the next `frame_start` → `aph`=0 and `acnt`=0.
- **Mid-frame change:** change `direction` from 0 to 3 between `frame_start` pulses → `rom_addr[12:11]` stays 0 until the next `frame_start`, then becomes 3.

Source files
------------

// File: rtl/zelda_sprite_fetch_if.sv
// Sprite ROM port plus the per-pixel result bus of the sprite fetch stage.
// The fetch block is the master; the ROM/palette side is the slave.
interface zelda_sprite_fetch_if #(
    parameter int SPR_LOG2 = 5
);
    logic [3+2*SPR_LOG2-1:0] rom_addr;
    logic [3:0]              rom_q;
    logic [3:0]              palette_index;
    logic                    pixel_hit;
    logic                    pixel_valid;

    modport master (
        output rom_addr,
        output palette_index,
        output pixel_hit,
        output pixel_valid,
        input  rom_q
    );

    modport slave (
        input  rom_addr,
        input  palette_index,
        input  pixel_hit,
        input  pixel_valid,
        output rom_q
    );
endinterface

// File: rtl/zelda_sprite_fetch.sv
// Per-pixel sprite fetch: frame-latched player state, walk animation, box test,
// sprite-ROM addressing and a fixed 3-cycle pipeline to the palette stage.
module zelda_sprite_fetch #(
    parameter int          SPR_LOG2    = 5,
    parameter int          ANIM_FRAMES = 8,
    parameter logic [3:0]  TRANSP_IDX  = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [1:0]  direction,
    input  logic        moving,
    zelda_sprite_fetch_if.master bus
);
    localparam int              AW        = 3 + 2*SPR_LOG2;
    localparam int              CW        = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [10:0]     SPR_EDGE  = 11'(1 << SPR_LOG2);
    localparam logic [CW-1:0]   ACNT_LAST = CW'(ANIM_FRAMES - 1);

    logic [9:0]          lx, ly;
    logic [1:0]          ldir;
    logic                lmov;
    logic [CW-1:0]       acnt;
    logic                aph;

    logic [AW-1:0]       rom_addr_reg;
    logic                in_box_d1, blank_d1;
    logic                in_box_d2, blank_d2;
    logic [3:0]          palette_index_reg;
    logic                pixel_hit_reg;
    logic                pixel_valid_reg;

    logic                mov_next;
    logic                in_box;
    logic [10:0]         x_ext, y_ext, lx_ext, ly_ext;
    logic [SPR_LOG2-1:0] dx, dy;
    logic [AW-1:0]       rom_addr_next;

    // Walk state seen by the animation: the fresh input on a frame pulse, else the latch.
    always_comb begin
        mov_next = lmov;
        if (frame_start) mov_next = moving;
    end

    // 11-bit compares so a sprite near x/y=1023 does not wrap its far edge.
    always_comb begin
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        lx_ext = {1'b0, lx};
        ly_ext = {1'b0, ly};
        in_box = (x_ext >= lx_ext) && (x_ext < lx_ext + SPR_EDGE) &&
                 (y_ext >= ly_ext) && (y_ext < ly_ext + SPR_EDGE);
        dx     = SPR_LOG2'(DrawX - lx);
        dy     = SPR_LOG2'(DrawY - ly);
        rom_addr_next = '0;
        if (in_box) rom_addr_next = {ldir, aph, dy, dx};
    end

    // Pixels sampled in the frame_start cycle still see the old latched state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lx   <= '0;
            ly   <= '0;
            ldir <= '0;
            lmov <= 1'b0;
            acnt <= '0;
            aph  <= 1'b0;
        end else if (frame_start) begin
            lx   <= sprite_x;
            ly   <= sprite_y;
            ldir <= direction;
            lmov <= mov_next;
            if (!mov_next) begin
                acnt <= '0;
                aph  <= 1'b0;
            end else if (acnt == ACNT_LAST) begin
                acnt <= '0;
                aph  <= ~aph;
            end else begin
                acnt <= acnt + 1'b1;
            end
        end
    end

    // S1 address, S2 alignment with the ROM register, S3 outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_reg      <= '0;
            in_box_d1         <= 1'b0;
            blank_d1          <= 1'b0;
            in_box_d2         <= 1'b0;
            blank_d2          <= 1'b0;
            palette_index_reg <= '0;
            pixel_hit_reg     <= 1'b0;
            pixel_valid_reg   <= 1'b0;
        end else begin
            rom_addr_reg      <= rom_addr_next;
            in_box_d1         <= in_box;
            blank_d1          <= blank;
            in_box_d2         <= in_box_d1;
            blank_d2          <= blank_d1;
            palette_index_reg <= in_box_d2 ? bus.rom_q : TRANSP_IDX;
            pixel_hit_reg     <= in_box_d2 && (bus.rom_q != TRANSP_IDX) && blank_d2;
            pixel_valid_reg   <= blank_d2;
        end
    end

    assign bus.rom_addr      = rom_addr_reg;
    assign bus.palette_index = palette_index_reg;
    assign bus.pixel_hit     = pixel_hit_reg;
    assign bus.pixel_valid   = pixel_valid_reg;
endmodule

// File: tb/tb_zelda_sprite_fetch.sv
// Scoreboard bench for zelda_sprite_fetch: directed pixels push hand-computed
// address and output expectations; monitors pop them at the aligned cycles.
module tb_zelda_sprite_fetch;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [9:0]  sprite_x, sprite_y;
    logic [1:0]  direction;
    logic        moving;

    zelda_sprite_fetch_if #(.SPR_LOG2(5)) bus ();

    zelda_sprite_fetch #(.SPR_LOG2(5), .ANIM_FRAMES(8), .TRANSP_IDX(4'h0)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .direction   (direction),
        .moving      (moving),
        .bus         (bus.master)
    );

    always #5 Clk = ~Clk;

    // ROM model: contents = low nibble of the address, one patched entry.
    logic [3:0] rom_mem [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 4'(i);
        rom_mem[13'h0843] = 4'h7;
    end
    always @(posedge Clk) bus.rom_q <= rom_mem[bus.rom_addr];

    typedef struct { string nm; logic [3:0] idx; logic hit; logic valid; } exp_t;
    typedef struct { string nm; logic [12:0] a; } addr_t;
    exp_t  exp_q [$];
    addr_t addr_q [$];

    int checks = 0;
    int errors = 0;

    logic tag;
    logic t1, t2, t3;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            t1 <= 1'b0; t2 <= 1'b0; t3 <= 1'b0;
        end else begin
            t1 <= tag; t2 <= t1; t3 <= t2;
        end
    end

    always @(negedge Clk) begin
        if (t1) begin
            addr_t ea;
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL addr_underflow: got rom_addr=%h, required a queued expectation", bus.rom_addr);
            end else begin
                ea = addr_q.pop_front();
                if (bus.rom_addr !== ea.a) begin
                    errors++;
                    $display("FAIL %s_addr: got rom_addr=%h, required %h", ea.nm, bus.rom_addr, ea.a);
                end else
                    $display("addr %s rom_addr=%h ok", ea.nm, bus.rom_addr);
            end
        end
        if (t3) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pix_underflow: got idx=%0d hit=%0d, required a queued expectation",
                         bus.palette_index, bus.pixel_hit);
            end else begin
                e = exp_q.pop_front();
                if (bus.palette_index !== e.idx || bus.pixel_hit !== e.hit || bus.pixel_valid !== e.valid) begin
                    errors++;
                    $display("FAIL %s: got idx=%0d hit=%0d valid=%0d, required idx=%0d hit=%0d valid=%0d",
                             e.nm, bus.palette_index, bus.pixel_hit, bus.pixel_valid, e.idx, e.hit, e.valid);
                end else
                    $display("pix %s idx=%0d hit=%0d valid=%0d ok",
                             e.nm, bus.palette_index, bus.pixel_hit, bus.pixel_valid);
            end
        end
    end

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end else
            $display("chk %s = %h ok", nm, got);
    endtask

    // Issue one tagged pixel; the caller is at posedge+1.
    task automatic pix(input string nm, input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic [12:0] ea, input logic [3:0] ei, input logic eh);
        DrawX = x; DrawY = y; blank = b; tag = 1'b1;
        addr_q.push_back('{nm, ea});
        exp_q.push_back('{nm, ei, eh, b});
        @(posedge Clk); #1;
        tag = 1'b0;
    endtask

    task automatic fs(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d, input logic m);
        sprite_x = x; sprite_y = y; direction = d; moving = m;
        frame_start = 1'b1; tag = 1'b0;
        DrawX = 10'd600; DrawY = 10'd400; blank = 1'b0;
        @(posedge Clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic anim_pix(input string nm, input logic a);
        pix(nm, 10'd101, 10'd51, 1'b1, {2'd0, a, 5'd1, 5'd1}, 4'd1, 1'b1);
    endtask

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; tag = 1'b0;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        sprite_x = '0; sprite_y = '0; direction = '0; moving = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_addr", bus.rom_addr, 13'd0);
        chk("reset_out", {8'd0, bus.palette_index, bus.pixel_hit}, 13'd0);
        chk("reset_valid", {12'd0, bus.pixel_valid}, 13'd0);
        Reset_n = 1'b1;

        // Sprite at (100,50), facing left, standing.
        fs(10'd100, 10'd50, 2'd1, 1'b0);
        pix("addr_lat",  10'd103, 10'd52, 1'b1, 13'b01_0_00010_00011, 4'd7,  1'b1);
        pix("x_edge131", 10'd131, 10'd52, 1'b1, {2'd1, 1'b0, 5'd2, 5'd31}, 4'd15, 1'b1);
        pix("x_edge132", 10'd132, 10'd52, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("x_edge99",  10'd99,  10'd52, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("transp_00", 10'd100, 10'd50, 1'b1, {2'd1, 1'b0, 5'd0, 5'd0}, 4'd0, 1'b0);
        pix("transp_16", 10'd116, 10'd81, 1'b1, {2'd1, 1'b0, 5'd31, 5'd16}, 4'd0, 1'b0);
        pix("blank_in",  10'd105, 10'd60, 1'b0, {2'd1, 1'b0, 5'd10, 5'd5}, 4'd5, 1'b0);
        pix("y_edge81",  10'd105, 10'd81, 1'b1, {2'd1, 1'b0, 5'd31, 5'd5}, 4'd5, 1'b1);
        pix("y_edge82",  10'd105, 10'd82, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("y_edge49",  10'd105, 10'd49, 1'b1, 13'd0, 4'd0, 1'b0);

        // frame_start coinciding with a box pixel: that pixel uses the old state.
        sprite_x = 10'd630; sprite_y = 10'd470; direction = 2'd2; moving = 1'b0;
        frame_start = 1'b1;
        pix("fs_same_cycle", 10'd103, 10'd52, 1'b1, 13'h0843, 4'd7, 1'b1);
        frame_start = 1'b0;
        pix("r_639",  10'd639, 10'd475, 1'b1, {2'd2, 1'b0, 5'd5, 5'd9},  4'd9,  1'b1);
        pix("r_661",  10'd661, 10'd475, 1'b1, {2'd2, 1'b0, 5'd5, 5'd31}, 4'd15, 1'b1);
        pix("r_662",  10'd662, 10'd475, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("r_629",  10'd629, 10'd475, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("r_x0",   10'd0,   10'd475, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("r_5_5",  10'd5,   10'd5,   1'b1, 13'd0, 4'd0, 1'b0);

        // Sprite whose far edge passes 1023: must not wrap.
        fs(10'd1000, 10'd1000, 2'd3, 1'b0);
        pix("wrap_in",  10'd1010, 10'd1020, 1'b1, {2'd3, 1'b0, 5'd20, 5'd10}, 4'd10, 1'b1);
        pix("wrap_x5",  10'd5,    10'd1020, 1'b1, 13'd0, 4'd0, 1'b0);
        pix("wrap_y5",  10'd1010, 10'd5,    1'b1, 13'd0, 4'd0, 1'b0);

        // Mid-frame direction change is ignored until the next frame_start.
        fs(10'd100, 10'd50, 2'd0, 1'b0);
        direction = 2'd3;
        pix("midframe_old", 10'd103, 10'd52, 1'b1, {2'd0, 1'b0, 5'd2, 5'd3}, 4'd3, 1'b1);
        fs(10'd100, 10'd50, 2'd3, 1'b0);
        pix("midframe_new", 10'd103, 10'd52, 1'b1, {2'd3, 1'b0, 5'd2, 5'd3}, 4'd3, 1'b1);

        // Walk animation: phase flips every 8 moving frames.
        fs(10'd100, 10'd50, 2'd0, 1'b0);
        for (int k = 0; k < 7; k++) fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_7", 1'b0);
        fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_8", 1'b1);
        for (int k = 0; k < 7; k++) fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_15", 1'b1);
        fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_16", 1'b0);
        for (int k = 0; k < 8; k++) fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_24", 1'b1);
        fs(10'd100, 10'd50, 2'd0, 1'b0);
        anim_pix("anim_stop", 1'b0);
        for (int k = 0; k < 7; k++) fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_restart7", 1'b0);
        fs(10'd100, 10'd50, 2'd0, 1'b1);
        anim_pix("anim_restart8", 1'b1);

        // Drain the scoreboard, then reset mid-stream while a hit is showing.
        repeat (4) @(posedge Clk);
        #1;
        DrawX = 10'd101; DrawY = 10'd51; blank = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("pre_reset_hit", {12'd0, bus.pixel_hit}, 13'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_addr", bus.rom_addr, 13'd0);
        chk("async_rst_out", {8'd0, bus.palette_index, bus.pixel_hit}, 13'd0);
        chk("async_rst_valid", {12'd0, bus.pixel_valid}, 13'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        DrawX = 10'd600; DrawY = 10'd400; blank = 1'b1;
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("post_rst_%0d", k), {8'd0, bus.palette_index, bus.pixel_hit}, 13'd0);
        end

        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d/%0d pending, required 0/0", exp_q.size(), addr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
